// File: rtl/mdu_ctrl_if.sv
// Bus between the E stage and the multiply/divide sequencer.
// The master side issues MD operations; the slave side is the unit itself.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        md_req_d;
  logic        busy;
  logic        stall_d;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, a, b, flush, md_req_d,
    input  busy, stall_d, hi, lo
  );

  modport slave (
    input  start, md_op, a, b, flush, md_req_d,
    output busy, stall_d, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: computes the result when an op is accepted, then holds
// Busy for a fixed latency before committing it to the architectural HI/LO pair.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  mdu_ctrl_if.slave  md_if
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [31:0]        r_hi;
  logic [31:0]        w_hi_next;
  logic [31:0]        r_lo;
  logic [31:0]        w_lo_next;
  logic [31:0]        r_tmp_hi;
  logic [31:0]        w_tmp_hi_next;
  logic [31:0]        r_tmp_lo;
  logic [31:0]        w_tmp_lo_next;
  logic               r_div_zero;
  logic               w_div_zero_next;
  logic               r_busy;

  logic               w_op_long;
  logic               w_op_valid;
  logic               w_is_div;
  logic               w_signed;
  logic               w_go;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [63:0]        w_a_ext;
  logic [63:0]        w_b_ext;
  logic [63:0]        w_prod;
  logic [31:0]        w_a_mag;
  logic [31:0]        w_b_mag;
  logic [31:0]        w_b_div;
  logic [31:0]        w_uq;
  logic [31:0]        w_ur;
  logic [31:0]        w_quot;
  logic [31:0]        w_rem;

  assign w_op_long  = (md_if.md_op >= OP_MULT) && (md_if.md_op <= OP_DIVU);
  assign w_op_valid = (md_if.md_op >= OP_MULT) && (md_if.md_op <= OP_MTLO);
  assign w_is_div   = (md_if.md_op == OP_DIV) || (md_if.md_op == OP_DIVU);
  assign w_signed   = (md_if.md_op == OP_MULT) || (md_if.md_op == OP_DIV);
  assign w_go       = md_if.start & ~md_if.flush & (r_state == S_IDLE) & w_op_valid;

  // One 64-bit multiplier serves both signednesses; only the low 64 bits are kept.
  assign w_a_neg = w_signed & md_if.a[31];
  assign w_b_neg = w_signed & md_if.b[31];
  assign w_a_ext = {{32{w_a_neg}}, md_if.a};
  assign w_b_ext = {{32{w_b_neg}}, md_if.b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed divide runs on magnitudes; 0x80000000 has magnitude 0x80000000 as unsigned,
  // so the overflow case falls out as quotient 0x80000000, remainder 0.
  assign w_a_mag = w_a_neg ? (~md_if.a + 32'd1) : md_if.a;
  assign w_b_mag = w_b_neg ? (~md_if.b + 32'd1) : md_if.b;
  assign w_b_div = (md_if.b == 32'd0) ? 32'd1 : w_b_mag;
  assign w_uq    = w_a_mag / w_b_div;
  assign w_ur    = w_a_mag % w_b_div;
  assign w_quot  = (w_a_neg ^ w_b_neg) ? (~w_uq + 32'd1) : w_uq;
  assign w_rem   = w_a_neg ? (~w_ur + 32'd1) : w_ur;

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_hi_next       = r_hi;
    w_lo_next       = r_lo;
    w_tmp_hi_next   = r_tmp_hi;
    w_tmp_lo_next   = r_tmp_lo;
    w_div_zero_next = r_div_zero;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          if (w_op_long) begin
            w_state_next = S_BUSY;
            if (w_is_div) begin
              w_tmp_hi_next   = w_rem;
              w_tmp_lo_next   = w_quot;
              w_cnt_next      = CNT_W'(DIV_CYCLES);
              w_div_zero_next = (md_if.b == 32'd0);
            end else begin
              w_tmp_hi_next   = w_prod[63:32];
              w_tmp_lo_next   = w_prod[31:0];
              w_cnt_next      = CNT_W'(MULT_CYCLES);
              w_div_zero_next = 1'b0;
            end
          end else if (md_if.md_op == OP_MTHI) begin
            w_hi_next = md_if.a;
          end else begin
            w_lo_next = md_if.a;
          end
        end
      end
      S_BUSY: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = S_IDLE;
          // A divide by zero burns the full latency but leaves HI/LO untouched.
          if (!r_div_zero) begin
            w_hi_next = r_tmp_hi;
            w_lo_next = r_tmp_lo;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_tmp_hi   <= '0;
      r_tmp_lo   <= '0;
      r_div_zero <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_hi       <= w_hi_next;
      r_lo       <= w_lo_next;
      r_tmp_hi   <= w_tmp_hi_next;
      r_tmp_lo   <= w_tmp_lo_next;
      r_div_zero <= w_div_zero_next;
      r_busy     <= (w_state_next == S_BUSY);
    end
  end

  assign md_if.busy    = r_busy;
  assign md_if.hi      = r_hi;
  assign md_if.lo      = r_lo;
  // Stalls D in the issue cycle too, before Busy has had a chance to rise.
  assign md_if.stall_d = md_if.md_req_d & (r_busy | (md_if.start & ~md_if.flush & w_op_long));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases with literal results, then random
// traffic compared every cycle against a timestamp-based behavioural model.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .md_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Result of an MD op from plain 64-bit arithmetic: {div_by_zero, hi, lo}.
  function automatic logic [64:0] model_calc(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    logic [63:0]     q;
    logic [63:0]     r;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    p  = '0;
    q  = '0;
    r  = '0;
    case (op)
      3'd1: begin p = sa * sb; return {1'b0, p[63:32], p[31:0]}; end
      3'd2: begin p = ua * ub; return {1'b0, p[63:32], p[31:0]}; end
      3'd3: begin
        if (b == 32'd0) return {1'b1, 64'd0};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, 64'd0};
        q = ua / ub;
        r = ua % ub;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Model: architectural HI/LO plus a pending result due at an absolute cycle index.
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  bit          m_pend;
  bit          m_dz;
  logic [31:0] m_pend_hi;
  logic [31:0] m_pend_lo;
  int          m_commit_at;
  int          m_cyc;

  always begin
    logic [64:0] res;
    bit          exp_stall;
    bit          long_op;
    @(negedge clk);
    #4;
    if (rst) begin
      m_hi   = '0;
      m_lo   = '0;
      m_pend = 1'b0;
    end
    long_op   = (bus.md_op >= 3'd1) && (bus.md_op <= 3'd4);
    exp_stall = bus.md_req_d && (m_pend || (bus.start && !bus.flush && long_op));
    chk("cyc_busy",  {31'd0, bus.busy},    {31'd0, m_pend});
    chk("cyc_stall", {31'd0, bus.stall_d}, {31'd0, exp_stall});
    chk("cyc_hi",    bus.hi, m_hi);
    chk("cyc_lo",    bus.lo, m_lo);
    if (!rst) begin
      if (m_pend) begin
        if (m_cyc == m_commit_at) begin
          if (!m_dz) begin
            m_hi = m_pend_hi;
            m_lo = m_pend_lo;
          end
          m_pend = 1'b0;
        end
      end else if (bus.start && !bus.flush && bus.md_op >= 3'd1 && bus.md_op <= 3'd6) begin
        if (bus.md_op == 3'd5) m_hi = bus.a;
        else if (bus.md_op == 3'd6) m_lo = bus.a;
        else begin
          res         = model_calc(bus.md_op, bus.a, bus.b);
          m_dz        = res[64];
          m_pend_hi   = res[63:32];
          m_pend_lo   = res[31:0];
          m_pend      = 1'b1;
          m_commit_at = m_cyc + ((bus.md_op <= 3'd2) ? MULT_N : DIV_N);
        end
      end
    end
    m_cyc++;
  end

  task automatic step(input bit st, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input bit fl, input bit rq);
    @(negedge clk);
    bus.start    = st;
    bus.md_op    = op;
    bus.a        = a;
    bus.b        = b;
    bus.flush    = fl;
    bus.md_req_d = rq;
  endtask

  task automatic idle(input int n, input bit rq);
    repeat (n) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, rq);
  endtask

  // Issue one long op with D requesting MD, then check latency and literal result.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] prev_hi,
                        input logic [31:0] prev_lo, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    n = (op <= 3'd2) ? MULT_N : DIV_N;
    step(1'b1, op, a, b, 1'b0, 1'b1);
    #1 chk({name, "_stall_start"}, {31'd0, bus.stall_d}, 32'd1);
    idle(1, 1'b1);
    #1 chk({name, "_busy_first"}, {31'd0, bus.busy}, 32'd1);
    idle(n - 1, 1'b1);
    #1;
    chk({name, "_busy_last"}, {31'd0, bus.busy}, 32'd1);
    chk({name, "_hi_hold"}, bus.hi, prev_hi);
    chk({name, "_lo_hold"}, bus.lo, prev_lo);
    idle(1, 1'b1);
    #1;
    chk({name, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
    chk({name, "_stall_done"}, {31'd0, bus.stall_d}, 32'd0);
    chk({name, "_hi"}, bus.hi, exp_hi);
    chk({name, "_lo"}, bus.lo, exp_lo);
    $display("op %0d a=%h b=%h -> hi=%h lo=%h", op, a, b, bus.hi, bus.lo);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    n_pass       = 0;
    n_total      = 0;
    m_cyc        = 0;
    m_pend       = 1'b0;
    m_hi         = '0;
    m_lo         = '0;
    m_commit_at  = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.md_op    = 3'd0;
    bus.a        = '0;
    bus.b        = '0;
    bus.flush    = 1'b0;
    bus.md_req_d = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2, 1'b0);

    run_op("mult",  3'd1, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFF1,
           32'h0000_0001, 32'hFFFF_FFFE);
    run_op("divu",  3'd4, 32'd100, 32'd7, 32'h0000_0001, 32'hFFFF_FFFE, 32'd2, 32'd14);
    run_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2, 32'd2, 32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           32'd0, 32'h8000_0000);

    step(1'b1, 3'd5, 32'hAA, 32'd0, 1'b0, 1'b1);
    #1 chk("mthi_no_stall", {31'd0, bus.stall_d}, 32'd0);
    idle(1, 1'b0);
    #1;
    chk("mthi_hi", bus.hi, 32'hAA);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    step(1'b1, 3'd5, 32'h1234, 32'd0, 1'b0, 1'b0);
    step(1'b1, 3'd6, 32'h5678, 32'd0, 1'b0, 1'b0);
    idle(1, 1'b0);
    #1;
    chk("mtlo_lo", bus.lo, 32'h5678);
    $display("mthi/mtlo -> hi=%h lo=%h", bus.hi, bus.lo);

    run_op("divzero", 3'd3, 32'd99, 32'd0, 32'h1234, 32'h5678, 32'h1234, 32'h5678);

    step(1'b1, 3'd1, 32'd3, 32'd3, 1'b1, 1'b1);
    #1 chk("flush_stall", {31'd0, bus.stall_d}, 32'd0);
    idle(1, 1'b1);
    #1;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    idle(MULT_N + 1, 1'b0);
    #1;
    chk("flush_hi", bus.hi, 32'h1234);
    chk("flush_lo", bus.lo, 32'h5678);
    $display("flushed mult -> busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);

    step(1'b1, 3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    idle(3, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(MULT_N + 3, 1'b0);
    #1;
    chk("arst_no_commit_hi", bus.hi, 32'd0);
    chk("arst_no_commit_lo", bus.lo, 32'd0);
    $display("async reset mid-mult -> busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    run_op("mult_post_rst", 3'd1, 32'd7, 32'd6, 32'd0, 32'd0, 32'd0, 32'd42);

    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = $urandom_range(0, 50);
        1:       ra = 32'h8000_0000;
        default: ra = $urandom();
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2, 3:    rb = $urandom_range(1, 20);
        default: rb = $urandom();
      endcase
      step($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), ra, rb,
           $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    end
    idle(DIV_N + 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
